// File: rtl/val2gen_pipe_pkg.sv
// Shared definitions for the pipelined ARM operand-2 generator.
package val2gen_pipe_pkg;

  // Default datapath width; matches the register length at the top level.
  localparam int unsigned DataWDefault = 32;

  // ARM shift-type codes, taken straight from instruction bits [6:5].
  typedef enum logic [1:0] {
    ShiftLsl = 2'b00,
    ShiftLsr = 2'b01,
    ShiftAsr = 2'b10,
    ShiftRor = 2'b11
  } shift_t;

  // Operand-2 source selected in stage 1.
  typedef enum logic [1:0] {
    ModeMem    = 2'b00,
    ModeImmRot = 2'b01,
    ModeShImm  = 2'b10,
    ModeShReg  = 2'b11
  } mode_t;

endpackage

// File: rtl/arm_shift_core.sv
// Combinational ARM barrel shifter with register-amount semantics:
// an 8-bit amount is range-checked at full width before any truncation.
module arm_shift_core
  import val2gen_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault,
  parameter int unsigned SH_W   = $clog2(DATA_W)
) (
  input  shift_t              shift_type,
  input  logic [7:0]          amount,
  input  logic [DATA_W-1:0]   rm,
  input  logic                c_in,
  output logic [DATA_W-1:0]   val2,
  output logic                carry
);

  localparam logic [8:0] FullAmt = 9'(DATA_W);

  logic [SH_W-1:0]   sh;
  logic              amt_zero;
  logic              amt_lt;
  logic              amt_eq;
  logic [DATA_W:0]   lsl_ext;
  logic [DATA_W:0]   lsr_ext;
  logic [DATA_W:0]   asr_ext;
  logic [DATA_W-1:0] ror_val;

  assign sh       = amount[SH_W-1:0];
  assign amt_zero = (amount == 8'd0);
  assign amt_lt   = ({1'b0, amount} < FullAmt);
  assign amt_eq   = ({1'b0, amount} == FullAmt);

  // One extra bit on each side catches the last bit shifted out as the carry.
  assign lsl_ext = {1'b0, rm} << sh;
  assign lsr_ext = {rm, 1'b0} >> sh;
  assign asr_ext = $signed({rm, 1'b0}) >>> sh;
  assign ror_val = (rm >> sh) | (rm << (DATA_W - int'(sh)));

  // Select result and carry by shift type and amount range.
  always_comb begin
    val2  = rm;
    carry = c_in;
    if (!amt_zero) begin
      unique case (shift_type)
        ShiftLsl: begin
          if (amt_lt) begin
            {carry, val2} = lsl_ext;
          end else begin
            val2  = '0;
            carry = amt_eq ? rm[0] : 1'b0;
          end
        end
        ShiftLsr: begin
          if (amt_lt) begin
            val2  = lsr_ext[DATA_W:1];
            carry = lsr_ext[0];
          end else begin
            val2  = '0;
            carry = amt_eq ? rm[DATA_W-1] : 1'b0;
          end
        end
        ShiftAsr: begin
          if (amt_lt) begin
            val2  = asr_ext[DATA_W:1];
            carry = asr_ext[0];
          end else begin
            val2  = {DATA_W{rm[DATA_W-1]}};
            carry = rm[DATA_W-1];
          end
        end
        ShiftRor: begin
          // A multiple of DATA_W leaves rm unchanged but still updates carry.
          if (sh == '0) begin
            carry = rm[DATA_W-1];
          end else begin
            val2  = ror_val;
            carry = ror_val[DATA_W-1];
          end
        end
        default: begin
          val2  = rm;
          carry = c_in;
        end
      endcase
    end
  end

endmodule

// File: rtl/val2gen_pipe.sv
// Two-stage valid/ready operand-2 generator: stage 1 decodes the instruction
// fields into (type, amount, operand, carry); stage 2 runs the barrel shifter.
module val2gen_pipe
  import val2gen_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault,
  parameter int unsigned SH_W   = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] val_rm,
  input  logic [DATA_W-1:0] val_rs,
  input  logic [11:0]       shift_operand,
  input  logic              immediate,
  input  logic              is_mem_command,
  input  logic              carry_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] val2_out,
  output logic              carry_out
);

  // Only Rs[7:0] supplies a shift amount.
  logic unused_rs_hi;
  assign unused_rs_hi = ^val_rs[DATA_W-1:8];

  logic              s1_valid_q;
  shift_t            s1_type_q;
  logic [7:0]        s1_amt_q;
  logic [DATA_W-1:0] s1_opnd_q;
  logic              s1_c_q;
  logic              s1_rrx_q;

  logic              s2_valid_q;
  logic [DATA_W-1:0] val2_q;
  logic              carry_q;

  mode_t             mode_d;
  shift_t            type_d;
  logic [7:0]        amt_d;
  logic [DATA_W-1:0] opnd_d;
  logic              rrx_d;

  logic              s1_adv;
  logic              in_fire;

  logic [DATA_W-1:0] core_val2;
  logic              core_carry;
  logic [DATA_W-1:0] s2_val2_d;
  logic              s2_carry_d;

  assign s1_adv   = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s1_adv;
  assign in_fire  = in_valid && in_ready;

  // Decode instruction fields into a uniform shifter request.
  always_comb begin
    type_d = shift_t'(shift_operand[6:5]);
    amt_d  = 8'd0;
    opnd_d = val_rm;
    rrx_d  = 1'b0;
    if (is_mem_command) begin
      mode_d = ModeMem;
    end else if (immediate) begin
      mode_d = ModeImmRot;
    end else if (shift_operand[4]) begin
      mode_d = ModeShReg;
    end else begin
      mode_d = ModeShImm;
    end
    unique case (mode_d)
      ModeMem: begin
        // LSL by zero passes the offset and carry straight through.
        type_d = ShiftLsl;
        opnd_d = DATA_W'(shift_operand);
      end
      ModeImmRot: begin
        type_d = ShiftRor;
        amt_d  = {3'b000, shift_operand[11:8], 1'b0};
        opnd_d = DATA_W'(shift_operand[7:0]);
      end
      ModeShReg: begin
        amt_d = val_rs[7:0];
      end
      ModeShImm: begin
        amt_d = {3'b000, shift_operand[11:7]};
        if (shift_operand[11:7] == 5'd0) begin
          unique case (type_d)
            ShiftLsl:           amt_d = 8'd0;
            ShiftLsr, ShiftAsr: amt_d = 8'(DATA_W);
            ShiftRor:           rrx_d = 1'b1;
            default:            amt_d = 8'd0;
          endcase
        end
      end
      default: begin
        amt_d = 8'd0;
      end
    endcase
  end

  // Stage 1 register: accepts whenever empty or draining into stage 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_type_q  <= ShiftLsl;
      s1_amt_q   <= 8'd0;
      s1_opnd_q  <= '0;
      s1_c_q     <= 1'b0;
      s1_rrx_q   <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid_q <= in_valid;
      end
      if (in_fire) begin
        s1_type_q <= type_d;
        s1_amt_q  <= amt_d;
        s1_opnd_q <= opnd_d;
        s1_c_q    <= carry_in;
        s1_rrx_q  <= rrx_d;
      end
    end
  end

  arm_shift_core #(
    .DATA_W (DATA_W),
    .SH_W   (SH_W)
  ) u_shift (
    .shift_type (s1_type_q),
    .amount     (s1_amt_q),
    .rm         (s1_opnd_q),
    .c_in       (s1_c_q),
    .val2       (core_val2),
    .carry      (core_carry)
  );

  // RRX shifts the old carry in at the top and is outside the core's amount model.
  always_comb begin
    s2_val2_d  = core_val2;
    s2_carry_d = core_carry;
    if (s1_rrx_q) begin
      s2_val2_d  = {s1_c_q, s1_opnd_q[DATA_W-1:1]};
      s2_carry_d = s1_opnd_q[0];
    end
  end

  // Stage 2 register: holds the result while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      val2_q     <= '0;
      carry_q    <= 1'b0;
    end else if (s1_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        val2_q  <= s2_val2_d;
        carry_q <= s2_carry_d;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign val2_out  = val2_q;
  assign carry_out = carry_q;

endmodule

// File: tb/tb_val2gen_pipe.sv
// Directed bench for val2gen_pipe: single transfers, shifter corner cases,
// backpressure and asynchronous reset.
module tb_val2gen_pipe;

  localparam int unsigned DATA_W = 32;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] val_rm;
  logic [DATA_W-1:0] val_rs;
  logic [11:0]       shift_operand;
  logic              immediate;
  logic              is_mem_command;
  logic              carry_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] val2_out;
  logic              carry_out;

  int errors = 0;
  int checks = 0;

  val2gen_pipe #(
    .DATA_W (DATA_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .val_rm         (val_rm),
    .val_rs         (val_rs),
    .shift_operand  (shift_operand),
    .immediate      (immediate),
    .is_mem_command (is_mem_command),
    .carry_in       (carry_in),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .val2_out       (val2_out),
    .carry_out      (carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] rm, input logic [31:0] rs, input logic [11:0] so,
                       input logic imm, input logic mem, input logic c);
    val_rm         = rm;
    val_rs         = rs;
    shift_operand  = so;
    immediate      = imm;
    is_mem_command = mem;
    carry_in       = c;
    in_valid       = 1'b1;
  endtask

  // One transfer through an empty pipe with out_ready high; checks 2-cycle latency.
  task automatic single(input string tag, input logic [31:0] rm, input logic [31:0] rs,
                        input logic [11:0] so, input logic imm, input logic mem, input logic c,
                        input logic [31:0] exp_v, input logic exp_c);
    out_ready = 1'b1;
    drive(rm, rs, so, imm, mem, c);
    #1;
    check({tag, ".in_ready"}, in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    check({tag, ".valid_early"}, out_valid, 1'b0);
    tick();
    check({tag, ".valid"}, out_valid, 1'b1);
    check({tag, ".val2"}, val2_out, exp_v);
    check({tag, ".carry"}, carry_out, exp_c);
    tick();
    check({tag, ".drained"}, out_valid, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    drive(32'h0, 32'h0, 12'h000, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    check("rst.out_valid", out_valid, 1'b0);
    check("rst.val2", val2_out, 32'h0);
    check("rst.carry", carry_out, 1'b0);
    #10;
    rst_n = 1'b1;
    tick();
    check("rst.in_ready_after", in_ready, 1'b1);
    check("rst.out_valid_after", out_valid, 1'b0);

    // Rotated immediates
    single("imm_rot4", 32'h0, 32'h0, 12'h4FF, 1'b1, 1'b0, 1'b0, 32'hFF00_0000, 1'b1);
    single("imm_rot0", 32'h0, 32'h0, 12'h0AB, 1'b1, 1'b0, 1'b1, 32'h0000_00AB, 1'b1);
    single("imm_rot1", 32'h0, 32'h0, 12'h103, 1'b1, 1'b0, 1'b0, 32'hC000_0000, 1'b1);
    // Immediate-amount shifts, including the #0 encodings
    single("lsl1", 32'h8000_0001, 32'h0, 12'h080, 1'b0, 1'b0, 1'b0, 32'h0000_0002, 1'b1);
    single("lsr0", 32'h8000_0001, 32'h0, 12'h020, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    single("rrx", 32'h0000_0003, 32'h0, 12'h060, 1'b0, 1'b0, 1'b1, 32'h8000_0001, 1'b1);
    single("asr0", 32'h8000_0000, 32'h0, 12'h040, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1);
    // Register-amount shifts
    single("rlsl32", 32'h1, 32'h20, 12'h010, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    single("rlsl33", 32'h1, 32'h21, 12'h010, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    single("rlsl0", 32'h1, 32'h00, 12'h010, 1'b0, 1'b0, 1'b1, 32'h1, 1'b1);
    single("rlsl_hi_ignored", 32'h1, 32'hFFFF_FF00, 12'h010, 1'b0, 1'b0, 1'b0, 32'h1, 1'b0);
    single("rlsr4", 32'hF, 32'h04, 12'h030, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    single("rlsr32", 32'h8000_0000, 32'h20, 12'h030, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    single("rasr64", 32'h8000_0010, 32'h40, 12'h050, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1);
    single("rror32", 32'h8000_0001, 32'h20, 12'h070, 1'b0, 1'b0, 1'b0, 32'h8000_0001, 1'b1);
    single("rror36", 32'h8000_0001, 32'h24, 12'h070, 1'b0, 1'b0, 1'b1, 32'h1800_0000, 1'b0);
    // Memory offset path overrides the I bit
    single("mem_c1", 32'hDEAD_BEEF, 32'h0, 12'hABC, 1'b1, 1'b1, 1'b1, 32'h0000_0ABC, 1'b1);
    single("mem_c0", 32'hDEAD_BEEF, 32'h0, 12'hABC, 1'b1, 1'b1, 1'b0, 32'h0000_0ABC, 1'b0);

    // Backpressure: fill both stages, hold, then drain with one new input per cycle
    out_ready = 1'b0;
    drive(32'h0, 32'h0, 12'h011, 1'b1, 1'b0, 1'b0);
    tick();
    drive(32'h0, 32'h0, 12'h022, 1'b1, 1'b0, 1'b0);
    #1;
    check("bp.ready_one_full", in_ready, 1'b1);
    tick();
    drive(32'h0, 32'h0, 12'h033, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp.ready_full", in_ready, 1'b0);
      check("bp.hold_valid", out_valid, 1'b1);
      check("bp.hold_val2", val2_out, 32'h11);
      check("bp.hold_carry", carry_out, 1'b0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp.ready_drain", in_ready, 1'b1);
    check("bp.out0", val2_out, 32'h11);
    tick();
    check("bp.valid1", out_valid, 1'b1);
    check("bp.out1", val2_out, 32'h22);
    drive(32'h0, 32'h0, 12'h103, 1'b1, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    check("bp.valid2", out_valid, 1'b1);
    check("bp.out2", val2_out, 32'h33);
    tick();
    check("bp.valid3", out_valid, 1'b1);
    check("bp.out3", val2_out, 32'hC000_0000);
    check("bp.carry3", carry_out, 1'b1);
    tick();
    check("bp.empty", out_valid, 1'b0);

    // Asynchronous reset with both stages holding data
    out_ready = 1'b0;
    drive(32'h0, 32'h0, 12'h0FF, 1'b1, 1'b0, 1'b1);
    tick();
    drive(32'h0, 32'h0, 12'h0EE, 1'b1, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    check("mid.full_valid", out_valid, 1'b1);
    check("mid.full_carry", carry_out, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid.rst_valid", out_valid, 1'b0);
    check("mid.rst_val2", val2_out, 32'h0);
    check("mid.rst_carry", carry_out, 1'b0);
    #10;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid.no_stale", out_valid, 1'b0);
    end
    check("mid.ready", in_ready, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
